down_counter_bank: RTL and testbench



---
 rtl/down_counter_bank_if.sv | 28 ++
 rtl/down_counter_bank.sv | 162 ++++++++++++++++
 tb/tb_down_counter_bank.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/down_counter_bank_if.sv
// Load/ack/read bus of the countdown timer bank; the bank itself is the slave.
interface down_counter_bank_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) ();
  localparam int IW = $clog2(N);

  logic             load_valid;
  logic             load_ready;
  logic [IW-1:0]    load_idx;
  logic [WIDTH-1:0] load_value;
  logic             ack_valid;
  logic [IW-1:0]    ack_idx;
  logic [IW-1:0]    rd_idx;
  logic [WIDTH-1:0] rd_count;
  logic [N-1:0]     expired;
  logic             irq;

  modport master (
    output load_valid, load_idx, load_value, ack_valid, ack_idx, rd_idx,
    input  load_ready, rd_count, expired, irq
  );

  modport slave (
    input  load_valid, load_idx, load_value, ack_valid, ack_idx, rd_idx,
    output load_ready, rd_count, expired, irq
  );
endinterface

// File: rtl/down_counter_bank.sv
// Bank of N countdown timers sharing one prescaler, with sticky expiry flags.
// Optional DOWN_COUNTER_BANK_AUTO_RELOAD_EN: periodic timers reloading on expiry.
module down_counter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             i_strobe,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  input  logic             i_ack,
  output logic             o_is_expired,
  output logic             o_exp_nxt,
  output logic             o_expired,
  output logic [WIDTH-1:0] o_count
);
  typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count, w_count_nxt;
  logic             r_exp, w_exp_nxt;
`ifdef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload, w_reload_nxt;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_exp   <= 1'b0;
`ifdef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_exp   <= w_exp_nxt;
`ifdef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
      r_reload <= w_reload_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_exp_nxt   = r_exp;
`ifdef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
    w_reload_nxt = r_reload;
    // ack is applied first so a same-cycle expiry re-sets the flag
    if (i_ack) w_exp_nxt = 1'b0;
    if (i_load) begin
      w_reload_nxt = i_load_value;
      w_count_nxt  = i_load_value;
      w_state_nxt  = (i_load_value != '0) ? RUNNING : IDLE;
    end else if (r_state == RUNNING && i_strobe) begin
      if (r_count == WIDTH'(1)) begin
        w_count_nxt = r_reload;
        w_exp_nxt   = 1'b1;
      end else begin
        w_count_nxt = r_count - WIDTH'(1);
      end
    end
`else
    // load is never presented while EXPIRED (load_ready gates it upstream)
    if (i_load) begin
      w_count_nxt = i_load_value;
      w_state_nxt = (i_load_value != '0) ? RUNNING : IDLE;
    end else begin
      case (r_state)
        RUNNING: if (i_strobe) begin
          if (r_count == WIDTH'(1)) begin
            w_count_nxt = '0;
            w_state_nxt = EXPIRED;
            w_exp_nxt   = 1'b1;
          end else begin
            w_count_nxt = r_count - WIDTH'(1);
          end
        end
        EXPIRED: if (i_ack) begin
          w_state_nxt = IDLE;
          w_exp_nxt   = 1'b0;
        end
        default: ;
      endcase
    end
`endif
  end

  assign o_is_expired = (r_state == EXPIRED);
  assign o_exp_nxt    = w_exp_nxt;
  assign o_expired    = r_exp;
  assign o_count      = r_count;
endmodule

module down_counter_bank #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  down_counter_bank_if.slave    bus
);
  localparam int IW = $clog2(N);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]             r_pre;
  logic                      w_strobe;
  logic                      w_load_ok;
  logic [N-1:0]              w_load, w_ack, w_is_exp, w_exp_nxt, w_exp;
  logic [N-1:0][WIDTH-1:0]   w_count;
  logic [WIDTH-1:0]          r_rd_count;
  logic                      r_irq;

  assign w_strobe = (r_pre == PW'(PRESCALE - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_pre <= '0;
    else          r_pre <= w_strobe ? '0 : r_pre + PW'(1);
  end

`ifdef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
  assign bus.load_ready = 1'b1;
`else
  assign bus.load_ready = ~w_is_exp[bus.load_idx];
`endif
  assign w_load_ok = bus.load_valid && bus.load_ready;

  for (genvar g = 0; g < N; g++) begin : g_lane
    assign w_load[g] = w_load_ok     && (bus.load_idx == IW'(g));
    assign w_ack[g]  = bus.ack_valid && (bus.ack_idx  == IW'(g));

    down_counter_lane #(.WIDTH(WIDTH)) u_lane (
      .clock        (clock),
      .reset_n      (reset_n),
      .i_strobe     (w_strobe),
      .i_load       (w_load[g]),
      .i_load_value (bus.load_value),
      .i_ack        (w_ack[g]),
      .o_is_expired (w_is_exp[g]),
      .o_exp_nxt    (w_exp_nxt[g]),
      .o_expired    (w_exp[g]),
      .o_count      (w_count[g])
    );
  end

  // irq is built from next-state flags so it lands on the same edge as expired
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_count <= '0;
      r_irq      <= 1'b0;
    end else begin
      r_rd_count <= w_count[bus.rd_idx];
      r_irq      <= |w_exp_nxt;
    end
  end

  assign bus.rd_count = r_rd_count;
  assign bus.expired  = w_exp;
  assign bus.irq      = r_irq;
endmodule

// File: tb/tb_down_counter_bank.sv
// Directed bench for down_counter_bank; read expectations flow through a scoreboard queue.
module tb_down_counter_bank;
  localparam int N = 4, WIDTH = 8, PRESCALE = 4;
  localparam int IW = $clog2(N);

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   cyc;
  int   checks   = 0;
  int   failures = 0;
  int   sb[$];

  down_counter_bank_if #(.N(N), .WIDTH(WIDTH)) bus ();

  down_counter_bank #(.N(N), .WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  // edges since reset release; strobe edges are multiples of PRESCALE
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      step();
      guard++;
    end
    if (cyc < n) chk("wait_bound", cyc, n);
  endtask

  task automatic read_chk(input int idx, input int exp, input string tag);
    sb.push_back(exp);
    bus.rd_idx = IW'(idx);
    step();
    chk(tag, bus.rd_count, sb.pop_front());
  endtask

  task automatic load(input int idx, input int val);
    bus.load_valid = 1'b1;
    bus.load_idx   = IW'(idx);
    bus.load_value = WIDTH'(val);
  endtask

  task automatic ack(input int idx);
    bus.ack_valid = 1'b1;
    bus.ack_idx   = IW'(idx);
  endtask

  task automatic ready_chk(input int idx, input logic exp, input string tag);
    bus.load_idx = IW'(idx);
    #1;
    chk(tag, bus.load_ready, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_valid = 1'b0; bus.load_idx = '0; bus.load_value = '0;
    bus.ack_valid  = 1'b0; bus.ack_idx  = '0; bus.rd_idx     = '0;
    repeat (3) step();
    chk("rst_expired", bus.expired, 0);
    chk("rst_irq", bus.irq, 0);
    chk("rst_rd_count", bus.rd_count, 0);
    ready_chk(0, 1'b1, "rst_ready");

    reset_n = 1'b1;
`ifndef DOWN_COUNTER_BANK_AUTO_RELOAD_EN
    load(0, 3); step(); bus.load_valid = 1'b0;
    read_chk(0, 3, "os_rd3");
    wait_to(4);  read_chk(0, 2, "os_rd2");
    wait_to(8);  read_chk(0, 1, "os_rd1");
    chk("os_not_yet", bus.expired, 0);
    wait_to(12);
    chk("os_expired", bus.expired, 4'b0001);
    chk("os_irq", bus.irq, 1);
    ready_chk(0, 1'b0, "os_ready_lo");
    // held load must not disturb the expired timer
    load(0, 9); step();
    chk("os_hold_ready", bus.load_ready, 0);
    chk("os_hold_exp", bus.expired, 4'b0001);
    read_chk(0, 0, "os_hold_cnt");
    // ack and held load together: only the ack lands, then the load retries
    ack(0); step(); bus.ack_valid = 1'b0;
    chk("ack_clear", bus.expired, 0);
    chk("ack_irq", bus.irq, 0);
    ready_chk(0, 1'b1, "ack_ready");
    step(); bus.load_valid = 1'b0;
    read_chk(0, 9, "retry_strobe_load");
    load(0, 0); step(); bus.load_valid = 1'b0;

    wait_to(19);
    load(1, 5); step(); bus.load_valid = 1'b0;
    read_chk(1, 5, "ld_strobe_col");
    read_chk(0, 0, "stop_by_zero");

    load(2, 2); step(); bus.load_valid = 1'b0;
    wait_to(27);
    ack(2); step(); bus.ack_valid = 1'b0;
    chk("ack_exp_col", bus.expired, 4'b0100);
    chk("ack_exp_irq", bus.irq, 1);
    ready_chk(2, 1'b0, "col_ready");

    load(3, 0); step(); bus.load_valid = 1'b0;
    ack(3); step(); bus.ack_valid = 1'b0;
    read_chk(3, 0, "zero_load_cnt");
    chk("zero_no_exp", bus.expired, 4'b0100);
    ready_chk(3, 1'b1, "idle_ready");

    wait_to(39); chk("t1_pre", bus.expired, 4'b0100);
    wait_to(40); chk("t1_exp", bus.expired, 4'b0110);
    read_chk(1, 0, "t1_cnt");
    ack(2); step(); bus.ack_valid = 1'b0;
    chk("ack2_only", bus.expired, 4'b0010);
    chk("ack2_irq", bus.irq, 1);

    load(0, 7); step(); bus.load_valid = 1'b0;
    read_chk(0, 7, "pre_rst_rd7");
    wait_to(46);
    chk("pre_rst_rd6", bus.rd_count, 6);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_rd", bus.rd_count, 0);
    chk("mid_rst_exp", bus.expired, 0);
    chk("mid_rst_irq", bus.irq, 0);
    step(); step();
    reset_n = 1'b1;
    load(0, 1); step(); bus.load_valid = 1'b0;
    read_chk(0, 1, "post_rst_ld");
    read_chk(1, 0, "post_rst_lost");
    chk("post_rst_no_exp", bus.expired, 0);
    wait_to(4);
    chk("first_strobe", bus.expired, 4'b0001);
    chk("first_strobe_irq", bus.irq, 1);
`else
    load(0, 2); step(); bus.load_valid = 1'b0;
    read_chk(0, 2, "ar_rd2a");
    wait_to(4);  read_chk(0, 1, "ar_rd1a");
    chk("ar_no_exp", bus.expired, 0);
    wait_to(8);
    chk("ar_exp1", bus.expired, 4'b0001);
    chk("ar_irq1", bus.irq, 1);
    ready_chk(0, 1'b1, "ar_ready");
    read_chk(0, 2, "ar_rd2b");
    ack(0); step(); bus.ack_valid = 1'b0;
    chk("ar_ack", bus.expired, 0);
    chk("ar_ack_irq", bus.irq, 0);
    wait_to(12); read_chk(0, 1, "ar_rd1b");
    wait_to(16);
    chk("ar_exp2", bus.expired, 4'b0001);
    ready_chk(0, 1'b1, "ar_ready2");
    read_chk(0, 2, "ar_rd2c");
    load(0, 0); step(); bus.load_valid = 1'b0;
    wait_to(24);
    read_chk(0, 0, "ar_stop");
    chk("ar_sticky", bus.expired, 4'b0001);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
